// File: rtl/ap_pkg.sv
// Shared types and helpers for the AP_s host sequencer: opcode, column and
// sequencer-state encodings plus a ceil(log2) helper for sizing counters.
package ap_pkg;

    typedef enum logic [2:0] {
        OP_OR   = 3'd0,
        OP_XOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_NOT  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_MULT = 3'd6
    } ap_op_t;

    typedef enum logic [1:0] {
        COL_A = 2'd0,
        COL_B = 2'd1,
        COL_C = 2'd2
    } ap_col_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR0,
        S_CLR1,
        S_LOAD_B,
        S_LOAD_A,
        S_COMPUTE,
        S_WAIT_IRQ,
        S_READ,
        S_HOLD
    } seq_state_t;

    // Smallest r with 2**r >= value, never less than 1.
    function automatic int clogb2(input int unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ap_rd_capture.sv
// Readback capture for AP_s column C: delays the read strobe by the AP read
// latency, latches the word and holds it under a valid/ready handshake.
module ap_rd_capture #(
    parameter int WORD_SIZE    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en_i,
    input  logic [WORD_SIZE-1:0] rd_data_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [WORD_SIZE-1:0] out_data_o
);

    logic [READ_LATENCY-1:0] lat_q;
    logic [READ_LATENCY:0]   lat_ext;
    logic                    valid_q;
    logic [WORD_SIZE-1:0]    data_q;

    assign lat_ext = {lat_q, rd_en_i};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            lat_q   <= '0;
            valid_q <= 1'b0;
            // NOTE: the holding register is reset as well so out_data reads 0 after reset.
            data_q  <= '0;
        end else begin
            lat_q <= lat_ext[READ_LATENCY-1:0];
            // Only one word is ever in flight, so capture never meets a pending word.
            if (lat_q[READ_LATENCY-1]) begin
                data_q  <= rd_data_i;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/ap_host_seq.sv
// Host-side sequencer for one AP_s instance: clears cols A/B, streams B then A,
// launches the op, waits for a fresh irq rise (with timeout) and streams col C out.
module ap_host_seq
    import ap_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int CELL_QUANT     = 512,
    parameter int ADDR_W         = clogb2(CELL_QUANT),
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    localparam int                TO_W     = clogb2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(CELL_QUANT - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    seq_state_t        state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    ap_op_t            op_q, op_d;
    logic              err_q, err_d;
    logic              irq_prev_q;

    logic              irq_rise;
    logic [TO_W-1:0]   cnt_inc;
    logic              timeout;
    logic              idx_last;
    logic              rd_valid;

    assign irq_rise = ap_state_irq && !irq_prev_q;
    assign cnt_inc  = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TO_W'(1);
    assign timeout  = (cnt_inc == TO_MAX);
    assign idx_last = (idx_q == LAST_IDX);

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            op_q       <= OP_OR;
            err_q      <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            err_q      <= err_d;
            irq_prev_q <= ap_state_irq;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = ap_op_t'(cmd_op);
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_CLR0;
                end
            end
            S_CLR0: state_d = S_CLR1;
            S_CLR1: state_d = S_LOAD_B;
            S_LOAD_B, S_LOAD_A: begin
                if (in_valid) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = (state_q == S_LOAD_B) ? S_LOAD_A : S_COMPUTE;
                    end else begin
                        idx_d = idx_q + (ADDR_W + 1)'(1);
                    end
                end
            end
            S_COMPUTE: begin
                cnt_d   = '0;
                state_d = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                cnt_d = cnt_inc;
                if (irq_rise) begin
                    state_d = S_READ;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READ: state_d = S_HOLD;
            S_HOLD: begin
                // HOLD also covers the read-latency wait before the word is valid.
                if (rd_valid && out_ready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + (ADDR_W + 1)'(1);
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready           = (state_q == S_IDLE);
        busy                = (state_q != S_IDLE);
        in_ready            = 1'b0;
        ap_rst              = 1'b0;
        ap_sel_internal_col = 1'b0;
        ap_write_en         = 1'b0;
        ap_read_en          = 1'b0;
        ap_mode             = 1'b0;
        ap_addr             = '0;
        ap_data             = '0;
        ap_cmd              = '0;
        ap_sel_col          = COL_A;
        case (state_q)
            S_CLR0: ap_rst = 1'b1;
            S_CLR1: begin
                ap_rst              = 1'b1;
                ap_sel_internal_col = 1'b1;
            end
            S_LOAD_B, S_LOAD_A: begin
                in_ready    = 1'b1;
                ap_write_en = in_valid;
                ap_addr     = idx_q[ADDR_W-1:0];
                ap_data     = in_data;
                ap_sel_col  = (state_q == S_LOAD_B) ? COL_B : COL_A;
            end
            S_COMPUTE: begin
                ap_mode = 1'b1;
                ap_cmd  = op_q;
            end
            S_WAIT_IRQ: begin
                // Mode drops in the same cycle the wait ends, on irq or timeout.
                ap_mode = !irq_rise && !timeout;
                ap_cmd  = op_q;
            end
            S_READ: begin
                ap_read_en = 1'b1;
                ap_addr    = idx_q[ADDR_W-1:0];
                ap_sel_col = COL_C;
            end
            default: ;
        endcase
    end

    ap_rd_capture #(
        .WORD_SIZE    (WORD_SIZE),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_capture (
        .clk         (CLK100MHZ),
        .rst         (rst),
        .rd_en_i     (ap_read_en),
        .rd_data_i   (ap_data_out),
        .out_ready_i (out_ready),
        .out_valid_o (rd_valid),
        .out_data_o  (out_data)
    );

    assign out_valid = rd_valid;
    assign out_last  = rd_valid && idx_last && (state_q == S_HOLD);
    assign err       = err_q;

endmodule
